// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: decoder-facing field types, offset selector
// and the fetch FSM encoding.
package fetch_unit_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int FUNC_MSB = 3;
    localparam int FUNC_LSB = 0;

    typedef logic [OPC_MSB-OPC_LSB:0]   opcode_t;
    typedef logic [FUNC_MSB-FUNC_LSB:0] control_e;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        FOURBIT   = 2'd1,
        EIGHTBIT  = 2'd2,
        TWELVEBIT = 2'd3
    } sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_target_calc.sv
// Branch/jump target: instr_pc plus the sign-extended offset field, wrapping
// modulo 2^ADDR_W. Only the 8- and 12-bit offset forms may redirect.
module pc_target_calc
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] instr_pc_i,
    input  logic [11:0]       instr_i,
    input  sel_t              offset_sel_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              redirect_ok_o
);

    // Wide enough for a 12-bit offset even when the PC is narrower.
    localparam int EXT_W = (ADDR_W > 12) ? ADDR_W : 12;

    logic [EXT_W-1:0] offset_ext;

    always_comb begin
        offset_ext    = '0;
        redirect_ok_o = 1'b0;
        case (offset_sel_i)
            EIGHTBIT: begin
                offset_ext    = {{(EXT_W-8){instr_i[7]}}, instr_i[7:0]};
                redirect_ok_o = 1'b1;
            end
            TWELVEBIT: begin
                offset_ext    = {{(EXT_W-12){instr_i[11]}}, instr_i[11:0]};
                redirect_ok_o = 1'b1;
            end
            default: begin
                offset_ext    = '0;
                redirect_ok_o = 1'b0;
            end
        endcase
    end

    assign target_o = instr_pc_i + offset_ext[ADDR_W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers one instruction per cycle,
// redirects on taken branches/jumps and stops for good on a halt request.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               take,
    input  sel_t               offset_sel,
    input  logic               halt_sys,
    output logic [INSTR_W-1:0] instr,
    output opcode_t            opcode,
    output control_e           func,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;

    logic [ADDR_W-1:0]  target;
    logic               redirect_ok;

    pc_target_calc #(.ADDR_W(ADDR_W)) u_target (
        .instr_pc_i    (instr_pc_q),
        .instr_i       (instr_q[11:0]),
        .offset_sel_i  (offset_sel),
        .target_o      (target),
        .redirect_ok_o (redirect_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    // Decoder strobes only steer the PC; they never reach instr_d, so there
    // is no combinational loop through opcode/func.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                pc_d    = '0;
                valid_d = 1'b0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (halt_sys && valid_q) begin
                    state_d = HALTED;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (take && valid_q && redirect_ok) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 1'b1;
                    end
                end
            end
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        imem_addr   = pc_q;
        instr       = instr_q;
        opcode      = instr_q[OPC_MSB:OPC_LSB];
        func        = instr_q[FUNC_MSB:FUNC_LSB];
        instr_pc    = instr_pc_q;
        instr_valid = valid_q;
        halted      = (state_q == HALTED);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios on a 16-bit and a 4-bit PC instance,
// then randomized decoder strobes against a behavioural model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit PC instance
    logic        rst_n_a, start_a, stall_a, take_a, halt_a;
    sel_t        sel_a;
    logic [15:0] addr_a, rdata_a, instr_a, ipc_a;
    opcode_t     opc_a;
    control_e    func_a;
    logic        valid_a, halted_a;
    logic [15:0] mem_a [0:65535];
    assign rdata_a = mem_a[addr_a];

    fetch_unit #(.ADDR_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a),
        .imem_addr(addr_a), .imem_rdata(rdata_a),
        .stall(stall_a), .take(take_a), .offset_sel(sel_a), .halt_sys(halt_a),
        .instr(instr_a), .opcode(opc_a), .func(func_a),
        .instr_pc(ipc_a), .instr_valid(valid_a), .halted(halted_a)
    );

    // 4-bit PC instance for wrap-around
    logic        rst_n_b, start_b, stall_b, take_b, halt_b;
    sel_t        sel_b;
    logic [3:0]  addr_b, ipc_b;
    logic [15:0] rdata_b, instr_b;
    opcode_t     opc_b;
    control_e    func_b;
    logic        valid_b, halted_b;
    logic [15:0] mem_b [0:15];
    assign rdata_b = mem_b[addr_b];

    fetch_unit #(.ADDR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b),
        .imem_addr(addr_b), .imem_rdata(rdata_b),
        .stall(stall_b), .take(take_b), .offset_sel(sel_b), .halt_sys(halt_b),
        .instr(instr_b), .opcode(opc_b), .func(func_b),
        .instr_pc(ipc_b), .instr_valid(valid_b), .halted(halted_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic [15:0] e_instr, input logic [15:0] e_ipc,
                         input logic e_valid, input logic [15:0] e_addr, input logic e_halted);
        check({tag, ".instr"},  instr_a,  e_instr);
        check({tag, ".opcode"}, opc_a,    e_instr[15:12]);
        check({tag, ".func"},   func_a,   e_instr[3:0]);
        check({tag, ".pc"},     ipc_a,    e_ipc);
        check({tag, ".valid"},  valid_a,  e_valid);
        check({tag, ".addr"},   addr_a,   e_addr);
        check({tag, ".halted"}, halted_a, e_halted);
    endtask

    task automatic chk_b(input string tag, input logic [15:0] e_instr, input logic [3:0] e_ipc,
                         input logic e_valid, input logic [3:0] e_addr);
        check({tag, ".instr"}, instr_b, e_instr);
        check({tag, ".pc"},    ipc_b,   e_ipc);
        check({tag, ".valid"}, valid_b, e_valid);
        check({tag, ".addr"},  addr_b,  e_addr);
    endtask

    task automatic step_a(input logic rs, input logic st, input logic sl, input logic tk,
                          input sel_t sel, input logic hl);
        rst_n_a = rs; start_a = st; stall_a = sl; take_a = tk; sel_a = sel; halt_a = hl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_b(input logic rs, input logic st, input logic tk, input sel_t sel);
        rst_n_b = rs; start_b = st; stall_b = 1'b0; take_b = tk; sel_b = sel; halt_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model state
    int          m_st;      // 0 idle, 1 run, 2 halted
    int          m_pc, m_ipc, m_off;
    logic [15:0] m_instr;
    logic        m_valid;
    logic        r_rst, r_start, r_stall, r_take, r_halt;
    sel_t        r_sel;

    initial begin
        for (int i = 0; i < 65536; i++) mem_a[i] = 16'h0000;
        for (int i = 0; i < 16; i++) mem_b[i] = 16'hB000 + 16'(i);
        step_b(1'b0, 1'b0, 1'b0, NONE);

        // Reset state and in-order fetch
        step_a(1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        step_a(1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        chk_a("reset", 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 5; k++) mem_a[k] = 16'h1000 + 16'(k);
        mem_a[5] = 16'h20FD;
        step_a(1'b1, 1'b1, 1'b0, 1'b0, NONE, 1'b0);
        chk_a("start", 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step_a(1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
            chk_a("seq", (k == 5) ? 16'h20FD : 16'h1000 + 16'(k), 16'(k), 1'b1, 16'(k + 1), 1'b0);
        end
        $display("seq fetch done: instr_pc=%0d", ipc_a);

        // Backward 8-bit branch at PC 5 -> 2
        step_a(1'b1, 1'b0, 1'b0, 1'b1, EIGHTBIT, 1'b0);
        chk_a("br8_bubble", 16'h20FD, 16'd5, 1'b0, 16'd2, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        chk_a("br8_tgt", 16'h1002, 16'd2, 1'b1, 16'd3, 1'b0);
        $display("branch8 done: instr_pc=%0d", ipc_a);

        // 12-bit jump at PC 3 with negative offset wraps to 0xF803
        step_a(1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        mem_a[3] = 16'h3800;
        mem_a[16'hF803] = 16'h4444;
        step_a(1'b1, 1'b1, 1'b0, 1'b0, NONE, 1'b0);
        for (int k = 0; k < 4; k++) step_a(1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        chk_a("j12_pre", 16'h3800, 16'd3, 1'b1, 16'd4, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b1, TWELVEBIT, 1'b0);
        chk_a("j12_bubble", 16'h3800, 16'd3, 1'b0, 16'hF803, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b1, EIGHTBIT, 1'b0);   // take during bubble is ignored
        chk_a("j12_tgt", 16'h4444, 16'hF803, 1'b1, 16'hF804, 1'b0);
        $display("jump12 done: instr_pc=0x%0h", ipc_a);

        // Stall over a pending branch, then halt with take and stall high
        step_a(1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        mem_a[3] = 16'h1003; mem_a[4] = 16'h2002; mem_a[5] = 16'h1005;
        mem_a[6] = 16'h1006; mem_a[7] = 16'h7007;
        step_a(1'b1, 1'b1, 1'b0, 1'b0, NONE, 1'b0);
        for (int k = 0; k < 5; k++) step_a(1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step_a(1'b1, 1'b0, 1'b1, 1'b1, EIGHTBIT, 1'b0);
            chk_a("stall_hold", 16'h2002, 16'd4, 1'b1, 16'd5, 1'b0);
        end
        step_a(1'b1, 1'b0, 1'b0, 1'b1, EIGHTBIT, 1'b0);
        chk_a("stall_redir", 16'h2002, 16'd4, 1'b0, 16'd6, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        chk_a("stall_tgt", 16'h1006, 16'd6, 1'b1, 16'd7, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        chk_a("pre_halt", 16'h7007, 16'd7, 1'b1, 16'd8, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 1'b1, TWELVEBIT, 1'b1);
        chk_a("halt", 16'h7007, 16'd7, 1'b0, 16'd8, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step_a(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), sel_t'($urandom_range(0, 3)), 1'($urandom));
            chk_a("halted_hold", 16'h7007, 16'd7, 1'b0, 16'd8, 1'b1);
        end
        step_a(1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        chk_a("halt_reset", 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        $display("halt/reset done: halted=%0d", halted_a);

        // 4-bit PC: wrap 14,15,0,1 then FOURBIT take is a plain fetch
        step_b(1'b0, 1'b0, 1'b0, NONE);
        step_b(1'b1, 1'b1, 1'b0, NONE);
        for (int k = 0; k < 14; k++) step_b(1'b1, 1'b0, 1'b0, NONE);
        chk_b("w13", 16'hB00D, 4'd13, 1'b1, 4'd14);
        for (int k = 14; k < 18; k++) begin
            step_b(1'b1, 1'b0, 1'b0, NONE);
            chk_b("wrap", 16'hB000 + 16'(k % 16), 4'(k % 16), 1'b1, 4'((k + 1) % 16));
        end
        step_b(1'b1, 1'b0, 1'b1, FOURBIT);
        chk_b("take4", 16'hB002, 4'd2, 1'b1, 4'd3);
        $display("addr4 wrap done: instr_pc=%0d", ipc_b);

        // Randomized run against the model
        for (int i = 0; i < 65536; i++) mem_a[i] = 16'($urandom);
        step_a(1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
        m_st = 0; m_pc = 0; m_ipc = 0; m_instr = '0; m_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(0, 99) >= 2);
            r_start = ($urandom_range(0, 99) < 15);
            r_stall = ($urandom_range(0, 99) < 20);
            r_take  = ($urandom_range(0, 99) < 30);
            r_halt  = ($urandom_range(0, 99) < 2);
            r_sel   = sel_t'($urandom_range(0, 3));
            if (!r_rst) begin
                m_st = 0; m_pc = 0; m_ipc = 0; m_instr = '0; m_valid = 1'b0;
            end else if (m_st == 0) begin
                if (r_start) m_st = 1;
            end else if (m_st == 1) begin
                if (r_halt && m_valid) begin
                    m_st = 2; m_valid = 1'b0;
                end else if (!r_stall) begin
                    if (r_take && m_valid && (r_sel == EIGHTBIT || r_sel == TWELVEBIT)) begin
                        if (r_sel == EIGHTBIT) begin
                            m_off = int'(m_instr[7:0]);
                            if (m_off >= 128) m_off -= 256;
                        end else begin
                            m_off = int'(m_instr[11:0]);
                            if (m_off >= 2048) m_off -= 4096;
                        end
                        m_pc = (m_ipc + m_off + 65536) % 65536;
                        m_valid = 1'b0;
                    end else begin
                        m_instr = mem_a[m_pc];
                        m_ipc   = m_pc;
                        m_valid = 1'b1;
                        m_pc    = (m_pc + 1) % 65536;
                    end
                end
            end
            step_a(r_rst, r_start, r_stall, r_take, r_sel, r_halt);
            chk_a("rnd", m_instr, 16'(m_ipc), m_valid, 16'(m_pc), (m_st == 2));
        end
        $display("random run done: %0d cycles", 3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage for the 16-bit CPU. It produces the instruction stream that the main control decoder consumes.
- Holds the program counter and reads instruction memory. Presents a registered instruction with its `opcode` and `func` fields and a valid flag.
- Uses the decoder's `offset_sel`, plus a branch/jump `take` strobe, to redirect the PC.
- Stops permanently when the decoder raises `halt_sys`.

## Interface
Parameters:
- `ADDR_W`, 16, instruction-memory word-address width; PC width.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: one-cycle pulse; leaves IDLE and begins fetching at address 0.
- `imem_addr` output ADDR_W: word address to instruction memory; equals PC register.
- `imem_rdata` input 16: instruction word at `imem_addr`; combinational-read memory, same cycle.
- `stall` input 1: hold the current instruction and the PC.
- `take` input 1: the presented instruction is a taken branch or a jump.
- `offset_sel` input sel_t: offset width chosen by the decoder for the presented instruction.
- `halt_sys` input 1: halt request from the decoder (HALT opcode, div0, overflow, illegal opcode).
- `instr` output 16: presented instruction register.
- `opcode` output opcode_t: `instr[15:12]`.
- `func` output control_e: `instr[3:0]`.
- `instr_pc` output ADDR_W: word address of `instr`.
- `instr_valid` output 1: `instr` is a real instruction, not a bubble.
- `halted` output 1: unit is in HALTED.

## Operation
States (fetch_state_t):
- **IDLE.** Entered on reset.
  - PC=0. `instr_valid`=0.
  - `start`=1 → RUN.
- **RUN.** Each edge, evaluated in priority order:
  1. `halt_sys` & `instr_valid` → HALTED. `instr_valid`←0. PC and `instr_pc` freeze. `instr` holds the halting word.
  2. `stall` → all registers hold.
  3. `take` & `instr_valid` & `offset_sel`∈{EIGHTBIT, TWELVEBIT}:
     - PC←target.
     - `instr_valid`←0. The wrong-path word on `imem_rdata` is dropped, giving exactly one bubble.
  4. Otherwise:
     - `instr`←`imem_rdata`, `instr_pc`←PC, `instr_valid`←1.
     - PC←PC+1.
- **HALTED.** Absorbing state; only `rst_n`=0 leaves it. `start`, `take` and `stall` are ignored.

Target arithmetic:
- target = `instr_pc` + sign-extended offset, modulo 2^ADDR_W.
- EIGHTBIT: sign-extend `instr[7:0]`.
- TWELVEBIT: sign-extend `instr[11:0]`.
- `take` with NONE or FOURBIT: no redirect; treat as a normal fetch.

Boundaries:
- PC increment wraps from 2^ADDR_W−1 to 0.
- `take` or `halt_sys` while `instr_valid`=0 is ignored.
- `stall` with `halt_sys`: halt wins.
- `stall` with `take`: stall wins. The redirect is taken on the first non-stalled cycle, provided `take` is still asserted.
- `start` while in RUN is ignored.

Reset (`rst_n`=0 at an edge, from any state, including mid-redirect or mid-stall):
- State←IDLE.
- PC=0, `instr`=16'h0000, `instr_pc`=0.
- `instr_valid`=0, `halted`=0.

## Timing
- `start` sampled at edge E0:
  - PC=0 from E0.
  - First valid `instr` (mem[0]) after edge E1.
  - One instruction per cycle thereafter.
- `opcode` and `func` are slices of the `instr` register, so they have no combinational path from `imem_rdata`.
- Redirect:
  - `take` sampled at edge Eb.
  - The cycle after Eb is a bubble; `imem_addr`=target.
  - The target instruction is valid after edge Eb+1.
- Halt:
  - `halted`=1 and `instr_valid`=0 the cycle after `halt_sys` is sampled.
  - `imem_addr` stays constant from then on.
- `halt_sys`, `take` and `offset_sel` are combinational from the decoder on `opcode`/`func` in the same cycle. This unit must not feed them back into `instr` combinationally.

## Structure
- `types_pkg` additions:
  - `fetch_state_t` enum: IDLE, RUN, HALTED.
  - `INSTR_W`=16.
  - Field-position constants: OPC_MSB=15, OPC_LSB=12, FUNC_MSB=3, FUNC_LSB=0.
- Reuse the existing `opcode_t`, `control_e` and `sel_t` from the shared packages.
- One sub-module, `pc_target_calc` (combinational): takes `instr_pc`, `instr` and `offset_sel`; produces the target and a `redirect_ok` flag.

## Test plan
1. Reset, `start`; memory holds 0x1000..0x1004 → `instr_valid` first rises one cycle after `start`; `instr_pc` counts 0,1,2,3 with matching words; `opcode` = `instr[15:12]`.
2. Branch at PC 5, `offset_sel`=EIGHTBIT, `instr[7:0]`=0xFD, `take`=1 → one bubble, then `instr_pc`=2.
3. Jump at PC 3, TWELVEBIT, `instr[11:0]`=0x800 → target = (3−2048) mod 65536 = 0xF803, reached after one bubble.
4. `stall` for 3 cycles at `instr_pc`=4 with `take`=1 → `instr` and PC hold; redirect happens on the first unstalled edge.
5. `halt_sys` at `instr_pc`=7, with `take` and `stall` also high → `halted`=1 and `instr_valid`=0 next cycle; `imem_addr` constant for 10 cycles; `rst_n` low → IDLE with all outputs at reset values.
6. ADDR_W=4, run from PC 14 → `instr_pc` 14, 15, 0, 1 (wrap); `take` with FOURBIT → no redirect.
